ahb_timer: RTL and testbench

AHB_TIMER -- requirements
Module: ahb_timer

---
 rtl/leg_timer_pkg.sv | 24 ++
 rtl/ahb_slave_if.sv | 80 ++++++++
 rtl/ahb_timer.sv | 142 ++++++++++++++
 tb/tb_ahb_timer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leg_timer_pkg.sv
// leg_timer_pkg: bus FSM state type, register word offsets and CTRL bit
// positions shared by the AHB timer and its bus interface.
package leg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  // Register word offsets, as decoded from HADDR[4:2]
  localparam logic [2:0] OFF_CTRL   = 3'd0;  // byte 0x00
  localparam logic [2:0] OFF_LOAD   = 3'd1;  // byte 0x04
  localparam logic [2:0] OFF_COUNT  = 3'd2;  // byte 0x08, read-only
  localparam logic [2:0] OFF_STATUS = 3'd3;  // byte 0x0C, PEND is write-1-to-clear
  localparam logic [2:0] OFF_PRESC  = 3'd4;  // byte 0x10, prescaler builds only

  // CTRL bit positions
  localparam int CTRL_EN   = 0;  // timer enable
  localparam int CTRL_AUTO = 1;  // reload from LOAD on expiry
  localparam int CTRL_IE   = 2;  // interrupt enable
  localparam int CTRL_FSEL = 3;  // route interrupt to FIQ instead of IRQ

endpackage

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: IDLE/WAIT/RESP handshake for the timer. Latches one access
// from IDLE, inserts WAIT_STATES wait cycles, then presents a single-cycle
// HREADY. The commit strobe is high for exactly that RESP cycle; the owner
// of the registers performs the write at the edge that ends it.
module ahb_slave_if
  import leg_timer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic        HREQUEST,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [2:0]  addr,
  output logic        write,
  output logic [31:0] wdata,
  output logic        commit
);

  // Wait counter preload; the WAIT state ends once the counter reads zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_e state, state_next;
  logic [3:0] wait_cnt;
  logic       take;
  logic       addr_unused;

  // Only HADDR[4:2] selects a register; the rest is deliberately ignored.
  assign addr_unused = ^{HADDR[31:5], HADDR[1:0]};

  // New accesses are accepted only from IDLE, so RESP is always followed
  // by at least one idle cycle.
  assign take = (state == IDLE) && HREQUEST && HSEL;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned
    // (which would infer a latch).
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Access latch and wait countdown; HREQUEST dropping later has no effect
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      write    <= 1'b0;
      wdata    <= '0;
      wait_cnt <= '0;
    end else if (take) begin
      addr     <= HADDR[4:2];
      write    <= HWRITE;
      wdata    <= HWDATA;
      wait_cnt <= WAIT_LOAD;
    end else if (state == WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign HREADY = (state == RESP);
  assign commit = (state == RESP);

endmodule

// File: rtl/ahb_timer.sv
// ahb_timer: 32-bit down-counting timer behind a simple AHB-style responder.
// Registers: CTRL (EN/AUTO/IE/FSEL), LOAD, COUNT (read-only), STATUS.PEND
// (write-1-to-clear). IRQ/FIQ are decoded purely from registered state.
// Build option: define TIMER_PRESCALE_EN to add the 8-bit PRESC register at
// offset 0x10, giving one tick every PRESC+1 cycles; otherwise every cycle
// is a tick and 0x10 reads as zero.
module ahb_timer
  import leg_timer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic        HREQUEST,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        IRQ,
  output logic        FIQ
);

  logic [2:0]  addr;
  logic        write;
  logic [31:0] wdata;
  logic        commit;

  logic [3:0]  ctrl;
  logic [31:0] load;
  logic [31:0] count;
  logic        pend;

  logic tick;
  logic expire;
  logic ctrl_wr;
  logic load_wr;
  logic status_clr;
  logic en_rise;

  ahb_slave_if #(
    .WAIT_STATES (WAIT_STATES)
  ) u_if (
    .clk      (clk),
    .reset    (reset),
    .HSEL     (HSEL),
    .HREQUEST (HREQUEST),
    .HWRITE   (HWRITE),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .commit   (commit)
  );

  // Register write decodes, all qualified by the RESP-cycle commit strobe.
  // COUNT and unmapped offsets have no decode, so writes there vanish.
  assign ctrl_wr    = commit & write & (addr == OFF_CTRL);
  assign load_wr    = commit & write & (addr == OFF_LOAD);
  assign status_clr = commit & write & (addr == OFF_STATUS) & wdata[0];
  assign en_rise    = ctrl_wr & wdata[CTRL_EN] & ~ctrl[CTRL_EN];
  assign expire     = ctrl[CTRL_EN] & tick & (count == '0);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc;
  logic [7:0] pcnt;
  logic       presc_wr;

  assign presc_wr = commit & write & (addr == OFF_PRESC);
  assign tick     = (pcnt == presc);

  // Prescaler: restarts on EN rising, wraps every PRESC+1 enabled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (presc_wr) presc <= wdata[7:0];
      if (en_rise)             pcnt <= '0;
      else if (ctrl[CTRL_EN])  pcnt <= tick ? 8'd0 : pcnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // CTRL: a bus write beats the one-shot expiry clearing EN on the same edge
  always_ff @(posedge clk) begin
    if (reset)                              ctrl <= '0;
    else if (ctrl_wr)                       ctrl <= wdata[3:0];
    else if (expire && !ctrl[CTRL_AUTO])    ctrl[CTRL_EN] <= 1'b0;
  end

  // LOAD: plain read/write register
  always_ff @(posedge clk) begin
    if (reset)        load <= '0;
    else if (load_wr) load <= wdata;
  end

  // COUNT: load on EN rising, decrement per tick, reload or park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en_rise) begin
      count <= load;
    end else if (ctrl[CTRL_EN] && tick) begin
      if (count != '0)          count <= count - 32'd1;
      else if (ctrl[CTRL_AUTO]) count <= load;
    end
  end

  // PEND: expiry set has priority over a simultaneous write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset)           pend <= 1'b0;
    else if (expire)     pend <= 1'b1;
    else if (status_clr) pend <= 1'b0;
  end

  // Read mux: the addressed register during RESP, zero at all other times
  always_comb begin
    HRDATA = '0;
    if (commit) begin
      case (addr)
        OFF_CTRL:   HRDATA = {28'd0, ctrl};
        OFF_LOAD:   HRDATA = load;
        OFF_COUNT:  HRDATA = count;
        OFF_STATUS: HRDATA = {31'd0, pend};
`ifdef TIMER_PRESCALE_EN
        OFF_PRESC:  HRDATA = {24'd0, presc};
`endif
        default:    HRDATA = '0;
      endcase
    end
  end

  assign IRQ = pend & ctrl[CTRL_IE] & ~ctrl[CTRL_FSEL];
  assign FIQ = pend & ctrl[CTRL_IE] &  ctrl[CTRL_FSEL];

endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: directed bench for ahb_timer (WAIT_STATES=1). The driver
// pushes the expected read data of each access into a scoreboard queue; a
// monitor pops and compares on every HREADY. Cycle-exact expectations are
// written relative to E, the clock edge that commits the enabling CTRL write.
module tb_ahb_timer;

  localparam int WS = 1;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_COUNT  = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_PRESC  = 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        HSEL, HREQUEST, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HREADY, IRQ, FIQ;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int ready_seen = 0;

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  ahb_timer #(.WAIT_STATES(WS)) dut (
    .clk      (clk),
    .reset    (reset),
    .HSEL     (HSEL),
    .HREQUEST (HREQUEST),
    .HWRITE   (HWRITE),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .IRQ      (IRQ),
    .FIQ      (FIQ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on HREADY, plus one-cycle HREADY / idle HRDATA
  logic prev_ready = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    if (prev_ready) begin
      check("hready_one_cycle", {31'd0, HREADY}, 32'd0);
      check("hrdata_after_resp", HRDATA, 32'd0);
    end
    if (HREADY) begin
      ready_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hready: got HREADY=1 with no access outstanding (t=%0t)", $time);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.is_read) check(nm, HRDATA, e.data);
      end
    end
    prev_ready = HREADY;
  end

  // One bus access issued in the cycle after the next rising edge. With drop
  // set, HREQUEST/HSEL/HWDATA are withdrawn during the WAIT cycle.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string name, input bit drop);
    int   start;
    bit   got;
    exp_t e;
    @(posedge clk);
    #1;
    HSEL = 1'b1; HREQUEST = 1'b1; HWRITE = wr; HADDR = addr; HWDATA = data;
    start = cyc;
    e.is_read = !wr;
    e.data    = exp;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (drop) begin
      @(posedge clk);
      #1;
      HSEL = 1'b0; HREQUEST = 1'b0; HWRITE = 1'b0; HWDATA = '0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (HREADY) got = 1'b1;
    end
    HSEL = 1'b0; HREQUEST = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no HREADY within 40 cycles, required one", name);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
      end
    end else begin
      check({name, "_latency"}, 32'(cyc - start), 32'(WS + 1));
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name);
    access(1'b1, addr, data, 32'd0, name, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    access(1'b0, addr, 32'd0, exp, name, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500 us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int seen;
    reset = 1'b1; HSEL = 1'b0; HREQUEST = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_hready", {31'd0, HREADY}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_fiq", {31'd0, FIQ}, 32'd0);
    rd(A_CTRL,   32'd0, "rst_ctrl");
    rd(A_LOAD,   32'd0, "rst_load");
    rd(A_COUNT,  32'd0, "rst_count");
    rd(A_STATUS, 32'd0, "rst_status");

    // Read-only COUNT and unmapped offsets
    wr(A_COUNT, 32'h55, "wr_count");
    rd(A_COUNT, 32'd0, "count_ro");
    wr(32'h1C, 32'hFFFF_FFFF, "wr_unmapped");
    rd(32'h1C, 32'd0, "rd_1c");
    rd(32'h14, 32'd0, "rd_14");
`ifndef TIMER_PRESCALE_EN
    wr(A_PRESC, 32'hFF, "wr_10");
    rd(A_PRESC, 32'd0, "rd_10_unmapped");
`endif

    // LOAD round trip; upper address bits are not decoded
    wr(A_LOAD, 32'hA5A5_1234, "wr_load");
    rd(A_LOAD, 32'hA5A5_1234, "rd_load");
    rd(32'h0000_1004, 32'hA5A5_1234, "rd_load_alias");

    // HREQUEST withdrawn during WAIT: latched write still completes
    access(1'b1, A_LOAD, 32'd3, 32'd0, "wr_load_drop", 1'b1);
    rd(A_LOAD, 32'd3, "rd_load_after_drop");

    // Auto-reload, LOAD=3: COUNT after edge E+n is 3-(n mod 4), PEND at E+4
    wr(A_CTRL, 32'h7, "wr_ctrl_7");                  // returns in cycle E-1
    check("auto_irq_before", {31'd0, IRQ}, 32'd0);
    rd(A_COUNT, 32'd1, "auto_count_e2");             // shows state after E+2
    @(negedge clk);                                  // cycle E+3
    check("auto_irq_e3", {31'd0, IRQ}, 32'd0);
    @(negedge clk);                                  // cycle E+4
    check("auto_irq_e4", {31'd0, IRQ}, 32'd1);
    check("auto_fiq_e4", {31'd0, FIQ}, 32'd0);
    rd(A_COUNT, 32'd0, "auto_count_e7");
    rd(A_COUNT, 32'd1, "auto_count_e10");
    rd(A_COUNT, 32'd2, "auto_count_e13");
    rd(A_COUNT, 32'd3, "auto_count_e16");
    rd(A_STATUS, 32'd1, "auto_pend");
    wr(A_CTRL, 32'd0, "auto_stop");
    wr(A_STATUS, 32'd1, "auto_clr");
    rd(A_STATUS, 32'd0, "auto_pend_clr");
    check("auto_irq_clr", {31'd0, IRQ}, 32'd0);

    // One-shot on FIQ with LOAD=0: expires at E+1 and clears EN
    wr(A_LOAD, 32'd0, "wr_load_0");
    wr(A_CTRL, 32'hD, "wr_ctrl_d");                  // returns in cycle E-1
    @(negedge clk);                                  // cycle E
    check("fiq_e0", {31'd0, FIQ}, 32'd0);
    @(negedge clk);                                  // cycle E+1
    check("fiq_e1", {31'd0, FIQ}, 32'd1);
    check("fiq_irq_e1", {31'd0, IRQ}, 32'd0);
    rd(A_CTRL, 32'hC, "fiq_en_cleared");
    rd(A_COUNT, 32'd0, "fiq_count_zero");
    wr(A_STATUS, 32'd1, "fiq_clr");
    wr(A_CTRL, 32'd0, "fiq_stop");
    check("fiq_after_clr", {31'd0, FIQ}, 32'd0);

    // W1C on the same edge as expiry (LOAD=2, auto: expiries at E+3k)
    wr(A_LOAD, 32'd2, "wr_load_2");
    wr(A_CTRL, 32'h7, "w1c_ctrl_7");                 // commits at E
    wr(A_STATUS, 32'd1, "w1c_at_expiry");            // commits at E+3
    rd(A_STATUS, 32'd1, "w1c_set_wins");             // shows state after E+5
    wr(A_CTRL, 32'h4, "w1c_ctrl_4");                 // commits at E+9 (expiry too)
    wr(A_STATUS, 32'd1, "w1c_no_expiry");            // commits at E+12
    rd(A_STATUS, 32'd0, "w1c_pend_clr");
    check("w1c_irq_clr", {31'd0, IRQ}, 32'd0);
    rd(A_CTRL, 32'h4, "w1c_ctrl_rd");

    // CTRL write on a one-shot expiry edge keeps EN (LOAD=2: expiry at E+3)
    wr(A_CTRL, 32'h5, "race_ctrl_5");                // commits at E
    wr(A_CTRL, 32'h7, "race_ctrl_7");                // commits at E+3
    rd(A_CTRL, 32'h7, "race_ctrl_wins");
    rd(A_COUNT, 32'd1, "race_count_e8");
    wr(A_CTRL, 32'd0, "race_stop");
    wr(A_STATUS, 32'd1, "race_clr");
    rd(A_STATUS, 32'd0, "race_pend_clr");

`ifdef TIMER_PRESCALE_EN
    // PRESC=2, LOAD=2, one-shot: tick every 3 cycles, expiry at E+9
    wr(A_PRESC, 32'd2, "wr_presc");
    rd(A_PRESC, 32'd2, "rd_presc");
    wr(A_LOAD, 32'd2, "presc_load");
    wr(A_CTRL, 32'h5, "presc_ctrl_5");               // returns in cycle E-1
    repeat (9) @(negedge clk);                       // cycle E+8
    check("presc_irq_e8", {31'd0, IRQ}, 32'd0);
    @(negedge clk);                                  // cycle E+9
    check("presc_irq_e9", {31'd0, IRQ}, 32'd1);
    rd(A_CTRL, 32'h4, "presc_en_cleared");
    wr(A_STATUS, 32'd1, "presc_clr");
    wr(A_PRESC, 32'd0, "presc_zero");
`endif

    // Reset asserted in the WAIT cycle of a CTRL=0x7 write
    @(posedge clk);
    #1;
    HSEL = 1'b1; HREQUEST = 1'b1; HWRITE = 1'b1; HADDR = A_CTRL; HWDATA = 32'h7;
    @(posedge clk);                                  // access accepted
    #1;
    reset = 1'b1; HSEL = 1'b0; HREQUEST = 1'b0;
    seen = ready_seen;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_hready", 32'(ready_seen - seen), 32'd0);
    rd(A_CTRL, 32'd0, "rst_mid_ctrl");
    rd(A_LOAD, 32'd0, "rst_mid_load");
    check("rst_mid_irq", {31'd0, IRQ}, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
